// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular transmit FIFO plus launch controller for a UART
// transmitter. Bytes written from MMIO are queued. The head byte is launched
// with a one-cycle tx_start whenever the transmitter is idle and launching is
// enabled. The next launch waits for tx_done_tick.
module uart_tx_fifo #(
   parameter int DBIT   = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic [DBIT-1:0]   w_data,
   input  logic              clr,
   input  logic              tx_en,
   input  logic              tx_done_tick,
   output logic              tx_start,
   output logic [DBIT-1:0]   tx_data,
   output logic              busy,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W:0]   COUNT_FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   COUNT_ZERO = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1'b1);
   localparam logic [ADDR_W-1:0] PTR_ZERO   = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1'b1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   logic [DBIT-1:0]   mem_r [DEPTH];
   logic [ADDR_W-1:0] w_ptr_r;
   logic [ADDR_W-1:0] r_ptr_r;
   logic [ADDR_W:0]   count_r;
   logic              overflow_r;
   state_t            state_r;
   state_t            state_s;
   logic              start_s;
   logic              push_s;
   logic              pop_s;

   // full is judged on the registered count only, so a same-cycle pop never
   // makes room for a write; clr discards any same-cycle write.
   assign full   = (count_r == COUNT_FULL);
   assign empty  = (count_r == COUNT_ZERO);
   assign push_s = wr & ~full & ~clr;
   assign pop_s  = start_s;

   // Storage write port; contents need no reset because count gates their use.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[w_ptr_r] <= w_data;
      end
   end

   // Pointer and occupancy bookkeeping, with clr overriding push and pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_ptr_r <= PTR_ZERO;
         r_ptr_r <= PTR_ZERO;
         count_r <= COUNT_ZERO;
      end else if (clr) begin
         w_ptr_r <= PTR_ZERO;
         r_ptr_r <= PTR_ZERO;
         count_r <= COUNT_ZERO;
      end else begin
         if (push_s) begin
            w_ptr_r <= w_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            r_ptr_r <= r_ptr_r + PTR_ONE;
         end
         if (push_s && !pop_s) begin
            count_r <= count_r + COUNT_ONE;
         end else if (!push_s && pop_s) begin
            count_r <= count_r - COUNT_ONE;
         end else begin
            count_r <= count_r;
         end
      end
   end

   // Sticky record of a write dropped because the FIFO was full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_r <= 1'b0;
      end else if (clr) begin
         overflow_r <= 1'b0;
      end else if (wr && full) begin
         overflow_r <= 1'b1;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   // Launch FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Launch decision: start from IDLE when enabled, data is queued and no
   // flush is in progress; stay BUSY until the transmitter reports done.
   always_comb begin
      state_s = state_r;
      start_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (tx_en && !empty && !clr) begin
               start_s = 1'b1;
               state_s = BUSY;
            end else begin
               state_s = IDLE;
            end
         end
         BUSY: begin
            if (tx_done_tick) begin
               state_s = IDLE;
            end else begin
               state_s = BUSY;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   assign tx_start = start_s;
   assign busy     = (state_r == BUSY);
   assign tx_data  = mem_r[r_ptr_r];
   assign count    = count_r;
   assign overflow = overflow_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench for uart_tx_fifo. The
// reference model is a byte queue plus a transmitter-busy flag and a sticky
// overflow flag, advanced once per clock edge.
module tb_uart_tx_fifo;

   logic       clk;
   logic       reset;
   logic       wr;
   logic [7:0] w_data;
   logic       clr;
   logic       tx_en;
   logic       tx_done_tick;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       busy;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] mq[$];
   bit         m_busy = 1'b0;
   bit         m_ovf  = 1'b0;

   uart_tx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
      .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .clr(clr),
      .tx_en(tx_en), .tx_done_tick(tx_done_tick), .tx_start(tx_start),
      .tx_data(tx_data), .busy(busy), .full(full), .empty(empty),
      .count(count), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: a launch happens when the transmitter is free, launching is
   // enabled, something is queued and no flush or reset is active.
   function automatic bit exp_start();
      return (!m_busy && tx_en === 1'b1 && mq.size() > 0 &&
              clr === 1'b0 && reset === 1'b0);
   endfunction

   // Advance one clock edge, updating the model from the inputs in force.
   task automatic step();
      bit st;
      bit was_full;
      @(posedge clk);
      st       = exp_start();
      was_full = (mq.size() == 16);
      if (reset) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_busy = 1'b0;
      end else begin
         if (clr) begin
            mq.delete();
            m_ovf = 1'b0;
         end else begin
            if (st) void'(mq.pop_front());
            if (wr) begin
               if (was_full) m_ovf = 1'b1;
               else mq.push_back(w_data);
            end
         end
         if (st) m_busy = 1'b1;
         else if (tx_done_tick) m_busy = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; wr = 1'b0; w_data = 8'h00; clr = 1'b0;
      tx_en = 1'b1; tx_done_tick = 1'b0;
      #12;
      n_checks++; if (count !== 5'd0) $display("FAIL reset_count: got %0d exp 0", count); else n_pass++;
      n_checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags: empty=%0b full=%0b exp 1/0", empty, full); else n_pass++;
      n_checks++; if (overflow !== 1'b0 || busy !== 1'b0 || tx_start !== 1'b0) $display("FAIL reset_ctrl: ovf=%0b busy=%0b start=%0b exp 0/0/0", overflow, busy, tx_start); else n_pass++;
      step();
      reset = 1'b0;
   endtask

   task automatic test_single();
      wr = 1'b1; w_data = 8'hA5; tx_en = 1'b1;
      #2;
      n_checks++; if (tx_start !== 1'b0) $display("FAIL single_no_early_start: got %0b exp 0", tx_start); else n_pass++;
      step();
      wr = 1'b0;
      #2;
      n_checks++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) $display("FAIL single_launch: start=%0b data=%02h exp 1/a5", tx_start, tx_data); else n_pass++;
      step();
      #2;
      n_checks++; if (busy !== 1'b1 || empty !== 1'b1 || tx_start !== 1'b0) $display("FAIL single_busy: busy=%0b empty=%0b start=%0b exp 1/1/0", busy, empty, tx_start); else n_pass++;
      step();
      tx_done_tick = 1'b1;
      #2;
      n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_at_done: got %0b exp 1", busy); else n_pass++;
      step();
      tx_done_tick = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         n_checks++; if (busy !== 1'b0 || tx_start !== 1'b0) $display("FAIL single_after_done_%0d: busy=%0b start=%0b exp 0/0", i, busy, tx_start); else n_pass++;
         step();
      end
   endtask

   task automatic test_overflow();
      logic [7:0] exp_b;
      int gap;
      tx_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         wr = 1'b1; w_data = 8'(i);
         step();
      end
      w_data = 8'hFF;
      step();
      wr = 1'b0;
      #2;
      n_checks++; if (full !== 1'b1 || count !== 5'd16) $display("FAIL ovf_full: full=%0b count=%0d exp 1/16", full, count); else n_pass++;
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0b exp 1", overflow); else n_pass++;
      n_checks++; if (tx_start !== 1'b0) $display("FAIL ovf_hold: start=%0b exp 0 with tx_en=0", tx_start); else n_pass++;
      tx_en = 1'b1;
      #1;
      for (int k = 0; k < 16; k++) begin
         exp_b = 8'(k);
         n_checks++; if (tx_start !== 1'b1 || tx_data !== exp_b) $display("FAIL drain_launch_%0d: start=%0b data=%02h exp 1/%02h", k, tx_start, tx_data, exp_b); else n_pass++;
         step();
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            #2;
            n_checks++; if (tx_start !== 1'b0 || busy !== 1'b1) $display("FAIL drain_wait_%0d: start=%0b busy=%0b exp 0/1", k, tx_start, busy); else n_pass++;
            step();
         end
         tx_done_tick = 1'b1;
         #2;
         n_checks++; if (tx_start !== 1'b0) $display("FAIL drain_done_cycle_%0d: start=%0b exp 0", k, tx_start); else n_pass++;
         step();
         tx_done_tick = 1'b0;
         #2;
      end
      n_checks++; if (tx_start !== 1'b0 || empty !== 1'b1 || overflow !== 1'b1) $display("FAIL drain_end: start=%0b empty=%0b ovf=%0b exp 0/1/1", tx_start, empty, overflow); else n_pass++;
   endtask

   task automatic test_wrap();
      int sent = 0;
      int launched = 0;
      int cyc = 0;
      logic [4:0] exp_cnt;
      tx_en = 1'b1;
      while ((sent < 40 || launched < 40) && cyc < 3000) begin
         wr = (sent < 40 && mq.size() < 16 && $urandom_range(0, 1) == 1);
         w_data = 8'($urandom);
         tx_done_tick = (m_busy && $urandom_range(0, 2) == 0);
         #2;
         exp_cnt = 5'(mq.size());
         n_checks++; if (tx_start !== exp_start()) $display("FAIL wrap_start_c%0d: got %0b exp %0b", cyc, tx_start, exp_start()); else n_pass++;
         if (exp_start()) begin
            n_checks++; if (tx_data !== mq[0]) $display("FAIL wrap_data_%0d: got %02h exp %02h", launched, tx_data, mq[0]); else n_pass++;
            launched++;
         end
         n_checks++; if (count !== exp_cnt || count > 5'd16) $display("FAIL wrap_count_c%0d: got %0d exp %0d", cyc, count, exp_cnt); else n_pass++;
         n_checks++; if (overflow !== m_ovf || busy !== m_busy) $display("FAIL wrap_flags_c%0d: ovf=%0b busy=%0b exp %0b/%0b", cyc, overflow, busy, m_ovf, m_busy); else n_pass++;
         if (wr) sent++;
         step();
         cyc++;
      end
      wr = 1'b0;
      n_checks++; if (launched != 40) $display("FAIL wrap_timeout: launched %0d exp 40", launched); else n_pass++;
      if (m_busy) begin
         tx_done_tick = 1'b1;
         step();
      end
      tx_done_tick = 1'b0;
      #2;
      n_checks++; if (busy !== 1'b0 || empty !== 1'b1) $display("FAIL wrap_end: busy=%0b empty=%0b exp 0/1", busy, empty); else n_pass++;
   endtask

   task automatic test_same_cycle();
      tx_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr = 1'b1; w_data = 8'hB0 + 8'(i);
         step();
      end
      wr = 1'b0; tx_en = 1'b1;
      #2;
      n_checks++; if (tx_start !== 1'b1 || tx_data !== 8'hB0) $display("FAIL same_first_launch: start=%0b data=%02h exp 1/b0", tx_start, tx_data); else n_pass++;
      step();
      wr = 1'b1; w_data = 8'hC4; tx_done_tick = 1'b1;
      #2;
      n_checks++; if (tx_start !== 1'b0 || count !== 5'd3 || busy !== 1'b1) $display("FAIL same_pre: start=%0b count=%0d busy=%0b exp 0/3/1", tx_start, count, busy); else n_pass++;
      step();
      wr = 1'b0; tx_done_tick = 1'b0;
      #2;
      n_checks++; if (tx_start !== 1'b1 || tx_data !== 8'hB1 || count !== 5'd4) $display("FAIL same_launch: start=%0b data=%02h count=%0d exp 1/b1/4", tx_start, tx_data, count); else n_pass++;
      step();
      #2;
      n_checks++; if (count !== 5'd3 || busy !== 1'b1 || tx_start !== 1'b0) $display("FAIL same_after: count=%0d busy=%0b start=%0b exp 3/1/0", count, busy, tx_start); else n_pass++;
   endtask

   task automatic test_clr();
      for (int i = 0; i < 2; i++) begin
         wr = 1'b1; w_data = 8'hD0 + 8'(i);
         step();
      end
      wr = 1'b0;
      #2;
      n_checks++; if (count !== 5'd5 || overflow !== 1'b1 || busy !== 1'b1) $display("FAIL clr_pre: count=%0d ovf=%0b busy=%0b exp 5/1/1", count, overflow, busy); else n_pass++;
      clr = 1'b1;
      #2;
      n_checks++; if (tx_start !== 1'b0) $display("FAIL clr_cycle_start: got %0b exp 0", tx_start); else n_pass++;
      step();
      clr = 1'b0;
      #2;
      n_checks++; if (count !== 5'd0 || overflow !== 1'b0 || empty !== 1'b1) $display("FAIL clr_flush: count=%0d ovf=%0b empty=%0b exp 0/0/1", count, overflow, empty); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (busy !== 1'b1 || tx_start !== 1'b0) $display("FAIL clr_inflight_%0d: busy=%0b start=%0b exp 1/0", i, busy, tx_start); else n_pass++;
         step();
         #2;
      end
      tx_done_tick = 1'b1;
      step();
      tx_done_tick = 1'b0;
      #2;
      n_checks++; if (busy !== 1'b0 || tx_start !== 1'b0) $display("FAIL clr_after_done: busy=%0b start=%0b exp 0/0", busy, tx_start); else n_pass++;
      wr = 1'b1; w_data = 8'hE7;
      step();
      wr = 1'b0; clr = 1'b1;
      #2;
      n_checks++; if (tx_start !== 1'b0) $display("FAIL clr_idle_suppress: got %0b exp 0", tx_start); else n_pass++;
      step();
      clr = 1'b0;
      #2;
      n_checks++; if (count !== 5'd0 || tx_start !== 1'b0 || busy !== 1'b0) $display("FAIL clr_idle_after: count=%0d start=%0b busy=%0b exp 0/0/0", count, tx_start, busy); else n_pass++;
   endtask

   task automatic test_reset_mid();
      tx_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wr = 1'b1; w_data = 8'h30 + 8'(i);
         step();
      end
      wr = 1'b0; tx_en = 1'b1;
      #2;
      n_checks++; if (tx_start !== 1'b1 || tx_data !== 8'h30) $display("FAIL rst_launch: start=%0b data=%02h exp 1/30", tx_start, tx_data); else n_pass++;
      step();
      #2;
      n_checks++; if (count !== 5'd2 || busy !== 1'b1) $display("FAIL rst_pre: count=%0d busy=%0b exp 2/1", count, busy); else n_pass++;
      reset = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b0 || empty !== 1'b1 || count !== 5'd0) $display("FAIL rst_async: busy=%0b empty=%0b count=%0d exp 0/1/0", busy, empty, count); else n_pass++;
      step();
      reset = 1'b0; tx_done_tick = 1'b1;
      #2;
      n_checks++; if (tx_start !== 1'b0) $display("FAIL rst_stray_done: start=%0b exp 0", tx_start); else n_pass++;
      step();
      tx_done_tick = 1'b0;
      #2;
      n_checks++; if (tx_start !== 1'b0 || busy !== 1'b0) $display("FAIL rst_after_stray: start=%0b busy=%0b exp 0/0", tx_start, busy); else n_pass++;
      wr = 1'b1; w_data = 8'h5A;
      step();
      wr = 1'b0;
      #2;
      n_checks++; if (tx_start !== 1'b1 || tx_data !== 8'h5A) $display("FAIL rst_relaunch: start=%0b data=%02h exp 1/5a", tx_start, tx_data); else n_pass++;
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_wrap();
      test_same_cycle();
      test_clr();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
